ps2_transmitter: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to a PS/2 device, such as keyboard LED set (0xED), reset (0xFF) or mouse enable-reporting (0xF4).
- It is the outbound counterpart of ps2_receiver and shares the open-drain clock/data lines with it.
- It performs the inhibit / request-to-send sequence, shifts bits on device clock edges, and checks the device acknowledge.
- It sits between command-generation logic and the top-level ps2_N_clock/ps2_N_data inout pads; the top level builds the tristates from the *_oe outputs.

---
 rtl/ps2_transmitter.sv | 132 +++++++++++++
 tb/tb_ps2_transmitter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: PS/2 host-to-device byte sender with inhibit/RTS, bit shifting and ack check.
// Optional PS2_TX_CLOCK_FILTER_EN adds a 16-sample stability filter on the device clock.
module ps2_transmitter #(
   parameter int CLK_FREQUENCY_HZ = 108_000_000,
   parameter int INHIBIT_US       = 100,
   parameter int TIMEOUT_US       = 15000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_request,
   output logic       ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] INHIBIT = 3'd1;
   localparam logic [2:0] RTS     = 3'd2;
   localparam logic [2:0] SHIFT   = 3'd3;
   localparam logic [2:0] ACK     = 3'd4;
   localparam logic [2:0] RELEASE = 3'd5;
   localparam int INHIBIT_CYCLES = CLK_FREQUENCY_HZ / 1_000_000 * INHIBIT_US;
   localparam int TIMEOUT_CYCLES = CLK_FREQUENCY_HZ / 1_000_000 * TIMEOUT_US;
   localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
   localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [1:0]  clk_s, dat_s;
   logic        clk_lvl, clk_prev, fall;
   logic [20:0] cnt;
   logic [9:0]  shift_reg;
   logic [3:0]  index;
   logic        ack_err;

   always_ff @(posedge clk)
      if (reset) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
      end else begin
         clk_s <= {clk_s[0], ps2_clock_in};
         dat_s <= {dat_s[0], ps2_data_in};
      end

`ifdef PS2_TX_CLOCK_FILTER_EN
   logic [3:0] filt_cnt;
   logic       clk_filt;
   always_ff @(posedge clk)
      if (reset) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s[1] == clk_filt) filt_cnt <= '0;
      else if (filt_cnt == 4'd15) begin
         clk_filt <= clk_s[1];
         filt_cnt <= '0;
      end else filt_cnt <= filt_cnt + 4'd1;
   assign clk_lvl = clk_filt;
`else
   assign clk_lvl = clk_s[1];
`endif

   assign fall = clk_prev & ~clk_lvl;

   always_ff @(posedge clk)
      if (reset) clk_prev <= 1'b1;
      else clk_prev <= clk_lvl;

   always_ff @(posedge clk)
      if (reset) begin
         state        <= IDLE;
         ps2_clock_oe <= 1'b0;
         ps2_data_oe  <= 1'b0;
         ready        <= 1'b1;
         busy         <= 1'b0;
         tx_done      <= 1'b0;
         tx_error     <= 1'b0;
         cnt          <= '0;
         index        <= '0;
         shift_reg    <= '1;
         ack_err      <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            IDLE:
               if (tx_request && ready) begin
                  shift_reg    <= {1'b1, ~^tx_data, tx_data};
                  ps2_clock_oe <= 1'b1;
                  ready        <= 1'b0;
                  busy         <= 1'b1;
                  cnt          <= '0;
                  ack_err      <= 1'b0;
                  state        <= INHIBIT;
               end else ready <= 1'b1;
            INHIBIT:
               if (cnt == INHIBIT_LAST) begin
                  ps2_clock_oe <= 1'b0;
                  ps2_data_oe  <= 1'b1;
                  cnt          <= '0;
                  index        <= '0;
                  state        <= RTS;
               end else cnt <= cnt + 21'd1;
            default: begin
               cnt <= fall ? '0 : cnt + 21'd1;
               // a fall always beats a coincident timeout
               if (state == RELEASE && clk_s[1] && dat_s[1]) begin
                  tx_done  <= ~ack_err;
                  tx_error <= ack_err;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (fall && state == ACK) begin
                  ack_err <= dat_s[1];
                  state   <= RELEASE;
               end else if (fall && state != RELEASE) begin
                  ps2_data_oe <= ~shift_reg[index];
                  index       <= index + 4'd1;
                  state       <= (index == 4'd9) ? ACK : SHIFT;
               end else if (!fall && cnt == TIMEOUT_LAST) begin
                  ps2_clock_oe <= 1'b0;
                  ps2_data_oe  <= 1'b0;
                  tx_error     <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
         endcase
      end
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed bench for ps2_transmitter with an open-drain PS/2 device model.
module tb_ps2_transmitter;
   localparam int H = 25;
`ifdef PS2_TX_CLOCK_FILTER_EN
   localparam int LAT = 19;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dev_clk = 1'b1;
   logic dev_dat = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic tx_request = 1'b0;
   logic ps2_clock_oe, ps2_data_oe, ready, tx_done, tx_error, busy;
   logic clock_line, data_line;
   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int oe_cycles = 0;
   int frames = 0;
   logic oe_prev = 1'b0;

   assign clock_line = dev_clk & ~ps2_clock_oe;
   assign data_line  = dev_dat & ~ps2_data_oe;

   ps2_transmitter #(.CLK_FREQUENCY_HZ(1_000_000)) dut (
      .clk(clk), .reset(reset),
      .ps2_clock_in(clock_line), .ps2_data_in(data_line),
      .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe),
      .tx_data(tx_data), .tx_request(tx_request),
      .ready(ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (ps2_clock_oe) oe_cycles++;
      if (ps2_clock_oe && !oe_prev) frames++;
      oe_prev = ps2_clock_oe;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic request(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_request = 1'b1;
      @(negedge clk);
      tx_request = 1'b0;
   endtask

   task automatic wait_rts();
      int n = 0;
      while (!(ps2_data_oe && !ps2_clock_oe) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rts_seen", 32'(n < 1000), 32'd1);
   endtask

   task automatic dev_pulse();
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   task automatic device_frame(input logic ack_low, output logic [10:0] bits);
      repeat (40) @(negedge clk);
      bits[0] = data_line;
      for (int k = 1; k <= 10; k++) begin
         dev_pulse();
         bits[k] = data_line;
      end
      dev_dat = ~ack_low;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_dat = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   initial begin
      repeat (400000) @(negedge clk);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] bits;
      int d0, e0, o0, f0, n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_error", 32'(tx_error), 32'd0);

      // 0xED with ack
      d0 = done_cnt; e0 = err_cnt; o0 = oe_cycles;
      request(8'hED);
      check("ed_ready_low", 32'(ready), 32'd0);
      check("ed_busy_high", 32'(busy), 32'd1);
      wait_rts();
      check("ed_inhibit_len", 32'(oe_cycles - o0), 32'd100);
      device_frame(1'b1, bits);
      check("ed_bits", 32'(bits), 32'h7DA);
      check("ed_done", 32'(done_cnt - d0), 32'd1);
      check("ed_err", 32'(err_cnt - e0), 32'd0);
      check("ed_ready_after", 32'(ready), 32'd1);
      check("ed_busy_after", 32'(busy), 32'd0);

      // 0xF4 with a silent device
      d0 = done_cnt; e0 = err_cnt;
      request(8'hF4);
      wait_rts();
      n = 0;
      while (!tx_error && n < 16000) begin
         @(negedge clk);
         n++;
      end
      check("f4_timeout_cycles", 32'(n), 32'd15000);
      check("f4_clock_oe", 32'(ps2_clock_oe), 32'd0);
      check("f4_data_oe", 32'(ps2_data_oe), 32'd0);
      repeat (5) @(negedge clk);
      check("f4_no_done", 32'(done_cnt - d0), 32'd0);
      check("f4_one_err", 32'(err_cnt - e0), 32'd1);

      // 0xFF with missing ack
      d0 = done_cnt; e0 = err_cnt;
      request(8'hFF);
      wait_rts();
      device_frame(1'b0, bits);
      check("ff_bits", 32'(bits), 32'h7FE);
      check("ff_parity", 32'(bits[9]), 32'd1);
      check("ff_err", 32'(err_cnt - e0), 32'd1);
      check("ff_no_done", 32'(done_cnt - d0), 32'd0);

      // held request plus a mid-frame request
      d0 = done_cnt; f0 = frames;
      @(negedge clk);
      tx_data = 8'h3C;
      tx_request = 1'b1;
      @(negedge clk);
      tx_data = 8'h00;
      repeat (4) @(negedge clk);
      tx_request = 1'b0;
      wait_rts();
      tx_request = 1'b1;
      @(negedge clk);
      tx_request = 1'b0;
      device_frame(1'b1, bits);
      check("hold_bits", 32'(bits), 32'h678);
      check("hold_done", 32'(done_cnt - d0), 32'd1);
      repeat (200) @(negedge clk);
      check("hold_frames", 32'(frames - f0), 32'd1);
      check("hold_clock_idle", 32'(ps2_clock_oe), 32'd0);
      check("hold_ready", 32'(ready), 32'd1);

      // reset while bit 4 is on the line
      d0 = done_cnt; e0 = err_cnt;
      request(8'hED);
      wait_rts();
      repeat (40) @(negedge clk);
      repeat (4) dev_pulse();
`ifdef PS2_TX_CLOCK_FILTER_EN
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_ignored", 32'(ps2_data_oe), 32'd0);
`endif
      dev_clk = 1'b0;
      n = 0;
      while (!ps2_data_oe && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("fall_latency", 32'(n), 32'(LAT));
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
      check("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("mid_rst_ready", 32'(ready), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      dev_clk = 1'b1;
      repeat (60) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
      request(8'hED);
      wait_rts();
      device_frame(1'b1, bits);
      check("post_rst_bits", 32'(bits), 32'h7DA);
      check("post_rst_done", 32'(done_cnt - d0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
